// File: rtl/key_event_decoder.sv
// key_event_decoder
// Turns a stream of PS/2 set-2 scancode bytes into {code, ext, break} key
// events. A four-state prefix parser handles E0/F0. An optional typematic
// repeat filter drops makes of a key that is already held. The resulting
// events sit in a small first-word-fall-through FIFO for the consumer.
// last_make follows the most recent non-suppressed make, for a display.

module key_event_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_FILTER = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_valid,
  input  logic                          evt_ready,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_break,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [7:0]                    last_make
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Stored entry layout: {code[7:0], ext, break}
  localparam int EW    = 10;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Parser states
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GOT_E0   = 2'd1;
  localparam logic [1:0] ST_GOT_F0   = 2'd2;
  localparam logic [1:0] ST_GOT_E0F0 = 2'd3;

  localparam logic [7:0] BYTE_E0 = 8'hE0;
  localparam logic [7:0] BYTE_F0 = 8'hF0;

  // Reject illegal depths at elaboration time
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((1 << PTR_W) != FIFO_DEPTH)) begin : g_bad_depth
    $error("key_event_decoder: FIFO_DEPTH must be a power of two in 2..16");
  end

  // ---------------------------------------------------------------------
  // Byte classification and parser
  // ---------------------------------------------------------------------
  logic [1:0] state_reg;
  logic [1:0] state_next;
  logic       is_ctrl;
  logic       is_e0;
  logic       is_f0;
  logic       is_code;
  logic       cur_ext;
  logic       cur_brk;
  logic       code_strobe;

  // Decode the incoming byte: host/keyboard control bytes, prefixes, or a code
  always_comb begin
    is_ctrl = byte_in inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    is_e0   = (byte_in == BYTE_E0);
    is_f0   = (byte_in == BYTE_F0);
    is_code = !is_ctrl && !is_e0 && !is_f0;
  end

  assign cur_ext     = (state_reg == ST_GOT_E0) || (state_reg == ST_GOT_E0F0);
  assign cur_brk     = (state_reg == ST_GOT_F0) || (state_reg == ST_GOT_E0F0);
  assign code_strobe = byte_valid && is_code;

  // Prefix accumulation; a repeated prefix leaves the state untouched
  always_comb begin
    state_next = state_reg;
    if (byte_valid) begin
      if (is_ctrl) begin
        state_next = ST_IDLE;
      end else if (is_e0) begin
        case (state_reg)
          ST_IDLE:   state_next = ST_GOT_E0;
          ST_GOT_F0: state_next = ST_GOT_E0F0;
          default:   state_next = state_reg;
        endcase
      end else if (is_f0) begin
        case (state_reg)
          ST_IDLE:   state_next = ST_GOT_F0;
          ST_GOT_E0: state_next = ST_GOT_E0F0;
          default:   state_next = state_reg;
        endcase
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Parser state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // Held-key tracking and repeat filter
  // ---------------------------------------------------------------------
  logic       held_valid_reg;
  logic [7:0] held_code_reg;
  logic       held_ext_reg;
  logic [7:0] last_make_reg;
  logic       held_match;
  logic       make_suppress;
  logic       emit_make;
  logic       emit_break;

  assign held_match    = held_valid_reg && (held_code_reg == byte_in) && (held_ext_reg == cur_ext);
  assign make_suppress = (REPEAT_FILTER != 0) && held_match;
  assign emit_make     = code_strobe && !cur_brk && !make_suppress;
  assign emit_break    = code_strobe && cur_brk;

  // A make (re)arms the held key; the matching release disarms it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held_valid_reg <= 1'b0;
      held_code_reg  <= 8'h00;
      held_ext_reg   <= 1'b0;
    end else if (emit_make) begin
      held_valid_reg <= 1'b1;
      held_code_reg  <= byte_in;
      held_ext_reg   <= cur_ext;
    end else if (emit_break && held_match) begin
      held_valid_reg <= 1'b0;
    end
  end

  // Display code follows every emitted make, even one the FIFO has to drop
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_make_reg <= 8'h00;
    end else if (emit_make) begin
      last_make_reg <= byte_in;
    end
  end

  // ---------------------------------------------------------------------
  // Event FIFO (first word fall through)
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0]         wr_ptr_reg;
  logic [PTR_W-1:0]         rd_ptr_reg;
  logic [CNT_W-1:0]         count_reg;
  logic                     overflow_reg;
  logic                     fifo_full;
  logic                     push_req;
  logic                     push_en;
  logic                     pop_en;
  logic                     drop;
  logic [EW-1:0]            push_word;
  logic [EW-1:0]            head_word;
  logic [FIFO_DEPTH*EW-1:0] entry_flat;

  assign fifo_full = (count_reg == DEPTH_CNT);
  assign evt_valid = (count_reg != '0);
  assign pop_en    = evt_valid && evt_ready;
  assign push_req  = emit_make || emit_break;
  // When full, a push only fits if the head leaves on the same edge
  assign push_en   = push_req && (!fifo_full || pop_en);
  assign drop      = push_req && fifo_full && !pop_en;
  assign push_word = {byte_in, cur_ext, cur_brk};

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
    logic [EW-1:0] word_reg;

    // Storage slot gi captures the pushed event when the write pointer selects it
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        word_reg <= '0;
      end else if (push_en && (wr_ptr_reg == PTR_W'(gi))) begin
        word_reg <= push_word;
      end
    end

    assign entry_flat[gi*EW +: EW] = word_reg;
  end

  // Head entry mux driven by the read pointer
  always_comb begin
    head_word = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (rd_ptr_reg == PTR_W'(i)) begin
        head_word = entry_flat[i*EW +: EW];
      end
    end
  end

  // Pointers wrap naturally since the depth is a power of two
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_en) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  // Occupancy: push and pop together leave the count unchanged
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_reg <= 1'b0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
    end
  end

  // Head fields read as zero while the FIFO is empty
  assign evt_code   = evt_valid ? head_word[EW-1:2] : 8'h00;
  assign evt_ext    = evt_valid ? head_word[1]      : 1'b0;
  assign evt_break  = evt_valid ? head_word[0]      : 1'b0;
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign last_make  = last_make_reg;

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder (FIFO_DEPTH=4, REPEAT_FILTER=1).
// Directed per-cycle vector table, hand-written reset/full-FIFO sequences,
// and randomized byte streams compared against an event-queue reference model.

module tb_key_event_decoder;

  localparam int D      = 4;
  localparam int FILTER = 1;

  logic       clock;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       evt_ready;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic [2:0] fifo_count;
  logic       overflow;
  logic [7:0] last_make;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  bit verbose = 0;

  key_event_decoder #(.FIFO_DEPTH(D), .REPEAT_FILTER(FILTER)) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_ready  (evt_ready),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_break  (evt_break),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .last_make  (last_make)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  evt_t       m_q[$];
  bit         m_pend_ext;
  bit         m_pend_brk;
  bit         m_held_valid;
  logic [7:0] m_held_code;
  bit         m_held_ext;
  logic [7:0] m_last;
  bit         m_ovf;

  task automatic model_reset();
    m_q.delete();
    m_pend_ext   = 0;
    m_pend_brk   = 0;
    m_held_valid = 0;
    m_held_code  = 8'h00;
    m_held_ext   = 0;
    m_last       = 8'h00;
    m_ovf        = 0;
  endtask

  // One clock edge of behaviour: prefixes are flags that accumulate until a code byte.
  task automatic model_step(input logic bv, input logic [7:0] b, input logic rdy);
    bit   pop;
    bit   push;
    bit   match;
    int   size_before;
    evt_t e;
    pop  = (m_q.size() != 0) && rdy;
    push = 0;
    e    = '0;
    if (bv) begin
      if (b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
        m_pend_ext = 0;
        m_pend_brk = 0;
      end else if (b == 8'hE0) begin
        m_pend_ext = 1;
      end else if (b == 8'hF0) begin
        m_pend_brk = 1;
      end else begin
        e.code = b;
        e.ext  = m_pend_ext;
        e.brk  = m_pend_brk;
        m_pend_ext = 0;
        m_pend_brk = 0;
        match = m_held_valid && (m_held_code == b) && (m_held_ext == e.ext);
        if (e.brk) begin
          push = 1;
          if (match) m_held_valid = 0;
        end else if (!(FILTER != 0 && match)) begin
          push         = 1;
          m_last       = b;
          m_held_valid = 1;
          m_held_code  = b;
          m_held_ext   = e.ext;
        end
      end
    end
    size_before = m_q.size();
    if (pop) begin
      n_pops++;
      if (verbose)
        $display("pop %0d: code=%h ext=%0b brk=%0b", n_pops, m_q[0].code, m_q[0].ext, m_q[0].brk);
      void'(m_q.pop_front());
    end
    if (push) begin
      if (size_before == D && !pop) m_ovf = 1;
      else m_q.push_back(e);
    end
  endtask

  function automatic logic [22:0] pack(input logic v, input logic [7:0] code, input logic ext,
                                       input logic brk, input logic [2:0] cnt, input logic ovf,
                                       input logic [7:0] last);
    return {v, code, ext, brk, cnt, ovf, last};
  endfunction

  function automatic logic [22:0] model_pack();
    evt_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    return pack(m_q.size() != 0, h.code, h.ext, h.brk, 3'(m_q.size()), m_ovf, m_last);
  endfunction

  task automatic check(input string name, input logic [22:0] exp);
    logic [22:0] got;
    got = {evt_valid, evt_code, evt_ext, evt_break, fifo_count, overflow, last_make};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b code=%h ext=%0b brk=%0b cnt=%0d ovf=%0b last=%h, expected v=%0b code=%h ext=%0b brk=%0b cnt=%0d ovf=%0b last=%h",
               name, got[22], got[21:14], got[13], got[12], got[11:9], got[8], got[7:0],
               exp[22], exp[21:14], exp[13], exp[12], exp[11:9], exp[8], exp[7:0]);
    end
  endtask

  // Drive one cycle at the falling edge, let the rising edge act, sample 1 time unit later.
  task automatic cycle(input logic bv, input logic [7:0] b, input logic rdy);
    @(negedge clock);
    byte_valid = bv;
    byte_in    = b;
    evt_ready  = rdy;
    @(posedge clock);
    model_step(bv, b, rdy);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic reset_pulse(input string name);
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    check(name, pack(0, 8'h00, 0, 0, 3'd0, 0, 8'h00));
    @(negedge clock);
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    evt_ready  = 1'b0;
    reset      = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       bv;
    logic [7:0] b;
    logic       rdy;
    logic       v;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [2:0] cnt;
    logic       ovf;
    logic [7:0] last;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic bv, input logic [7:0] b, input logic rdy, input logic v,
                     input logic [7:0] code, input logic ext, input logic brk,
                     input logic [2:0] cnt, input logic ovf, input logic [7:0] last);
    vec_t t;
    t.bv = bv; t.b = b; t.rdy = rdy; t.v = v; t.code = code; t.ext = ext;
    t.brk = brk; t.cnt = cnt; t.ovf = ovf; t.last = last;
    vecs.push_back(t);
  endtask

  logic [7:0] pool [12];

  initial begin
    reset      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    evt_ready  = 1'b0;
    model_reset();

    pool = '{8'h1C, 8'h15, 8'h75, 8'h24, 8'h2D, 8'h35, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hAA, 8'hFA};

    // make/break of 1C with consumer always ready
    add(1, 8'h1C, 1,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0, 0, 8'h1C);
    add(1, 8'h1C, 1,  1, 8'h1C, 0, 1, 1, 0, 8'h1C);
    add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 8'h1C);
    // extended key 75 make/break
    add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0, 0, 8'h1C);
    add(1, 8'h75, 1,  1, 8'h75, 1, 0, 1, 0, 8'h75);
    add(1, 8'hE0, 1,  0, 8'h00, 0, 0, 0, 0, 8'h75);
    add(1, 8'hF0, 1,  0, 8'h00, 0, 0, 0, 0, 8'h75);
    add(1, 8'h75, 1,  1, 8'h75, 1, 1, 1, 0, 8'h75);
    add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 8'h75);
    // typematic repeats suppressed, consumer stalled
    add(1, 8'h1C, 0,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(1, 8'h1C, 0,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(1, 8'h1C, 0,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(1, 8'hF0, 0,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(1, 8'h1C, 0,  1, 8'h1C, 0, 0, 2, 0, 8'h1C);
    add(1, 8'h1C, 0,  1, 8'h1C, 0, 0, 3, 0, 8'h1C);
    add(0, 8'h00, 1,  1, 8'h1C, 0, 1, 2, 0, 8'h1C);
    add(0, 8'h00, 1,  1, 8'h1C, 0, 0, 1, 0, 8'h1C);
    add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 0, 8'h1C);
    // fill and overflow with six distinct makes
    add(1, 8'h15, 0,  1, 8'h15, 0, 0, 1, 0, 8'h15);
    add(1, 8'h1D, 0,  1, 8'h15, 0, 0, 2, 0, 8'h1D);
    add(1, 8'h24, 0,  1, 8'h15, 0, 0, 3, 0, 8'h24);
    add(1, 8'h2D, 0,  1, 8'h15, 0, 0, 4, 0, 8'h2D);
    add(1, 8'h2C, 0,  1, 8'h15, 0, 0, 4, 1, 8'h2C);
    add(1, 8'h35, 0,  1, 8'h15, 0, 0, 4, 1, 8'h35);
    add(0, 8'h00, 1,  1, 8'h1D, 0, 0, 3, 1, 8'h35);
    add(0, 8'h00, 1,  1, 8'h24, 0, 0, 2, 1, 8'h35);
    add(0, 8'h00, 1,  1, 8'h2D, 0, 0, 1, 1, 8'h35);
    add(0, 8'h00, 1,  0, 8'h00, 0, 0, 0, 1, 8'h35);

    #3;
    check("reset_state", pack(0, 8'h00, 0, 0, 3'd0, 0, 8'h00));
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].bv, vecs[i].b, vecs[i].rdy);
      $display("vec %0d: bv=%0b byte=%h rdy=%0b -> v=%0b code=%h ext=%0b brk=%0b cnt=%0d ovf=%0b last=%h",
               i, vecs[i].bv, vecs[i].b, vecs[i].rdy, evt_valid, evt_code, evt_ext, evt_break,
               fifo_count, overflow, last_make);
      check($sformatf("vec%0d", i), pack(vecs[i].v, vecs[i].code, vecs[i].ext, vecs[i].brk,
                                         vecs[i].cnt, vecs[i].ovf, vecs[i].last));
    end

    // Full FIFO with push and pop on the same edge: count holds, no overflow
    reset_pulse("reset_clears_overflow");
    cycle(1, 8'h15, 0);
    cycle(1, 8'h1D, 0);
    cycle(1, 8'h24, 0);
    cycle(1, 8'h2D, 0);
    check("full_count", pack(1, 8'h15, 0, 0, 3'd4, 0, 8'h2D));
    cycle(1, 8'h2C, 1);
    check("full_push_pop", pack(1, 8'h1D, 0, 0, 3'd4, 0, 8'h2C));
    cycle(0, 8'h00, 1);
    check("drain_24", pack(1, 8'h24, 0, 0, 3'd3, 0, 8'h2C));
    cycle(0, 8'h00, 1);
    check("drain_2d", pack(1, 8'h2D, 0, 0, 3'd2, 0, 8'h2C));
    cycle(0, 8'h00, 1);
    check("tail_2c", pack(1, 8'h2C, 0, 0, 3'd1, 0, 8'h2C));
    cycle(0, 8'h00, 1);
    check("drained", pack(0, 8'h00, 0, 0, 3'd0, 0, 8'h2C));

    // Control byte cancels a pending E0
    reset_pulse("reset_2");
    cycle(1, 8'hE0, 0);
    cycle(1, 8'hAA, 0);
    check("ctrl_no_event", pack(0, 8'h00, 0, 0, 3'd0, 0, 8'h00));
    cycle(1, 8'h1C, 0);
    check("ctrl_cancels_e0", pack(1, 8'h1C, 0, 0, 3'd1, 0, 8'h1C));
    // Reset with a pending F0 and a queued event: everything clears, prefix lost
    cycle(1, 8'hF0, 0);
    check("pending_f0", pack(1, 8'h1C, 0, 0, 3'd1, 0, 8'h1C));
    reset_pulse("reset_mid_prefix");
    cycle(1, 8'h1C, 0);
    check("after_reset_make", pack(1, 8'h1C, 0, 0, 3'd1, 0, 8'h1C));
    cycle(0, 8'h00, 0);
    check("idle_no_byte", pack(1, 8'h1C, 0, 0, 3'd1, 0, 8'h1C));

    // Randomized streams against the reference model
    verbose = 1;
    for (int run = 0; run < 3; run++) begin
      reset_pulse($sformatf("reset_rand%0d", run));
      for (int n = 0; n < 600; n++) begin
        logic bv;
        logic rdy;
        logic [7:0] b;
        bv  = ($urandom_range(0, 9) < 7);
        b   = pool[$urandom_range(0, 11)];
        rdy = ($urandom_range(0, 9) < (run == 0 ? 3 : (run == 1 ? 6 : 9)));
        cycle(bv, b, rdy);
        check($sformatf("rand%0d_%0d", run, n), model_pack());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter REPEAT_FILTER, default 1; 1 = suppress typematic repeats, 0 = pass all makes.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 byte_in  input  8  scancode byte from the PS/2 deserializer.
REQ-006 byte_valid  input  1  one-cycle strobe; byte_in valid this cycle.
REQ-007 evt_ready  input  1  consumer accepts the head event this cycle.
REQ-008 evt_valid  output  1  FIFO non-empty; head event present.
REQ-009 evt_code  output  8  head event base scancode.
REQ-010 evt_ext  output  1  head event carried an E0 prefix.
REQ-011 evt_break  output  1  head event is a release (F0 prefix).
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-013 overflow  output  1  sticky; an event was dropped because the FIFO was full.
REQ-014 last_make  output  8  code of the most recent emitted make; drives the 7-segment decoder.

Function
REQ-015 Bytes SHALL be sampled only in cycles with byte_valid=1; byte_in is ignored otherwise.
REQ-016 The parser FSM SHALL have states IDLE, GOT_E0, GOT_F0, GOT_E0F0.
REQ-017 Transitions SHALL be: E0 from IDLE->GOT_E0, from GOT_F0->GOT_E0F0, otherwise unchanged; F0 from IDLE->GOT_F0, from GOT_E0->GOT_E0F0, otherwise unchanged.
REQ-018 Control bytes 00, AA, E1, EE, FA, FE, FF SHALL be discarded in any state, forcing IDLE and emitting nothing.
REQ-019 Any other byte SHALL emit event {code=byte, ext=(state in GOT_E0/GOT_E0F0), break=(state in GOT_F0/GOT_E0F0)} and return to IDLE.
REQ-020 A held register {valid, code, ext} SHALL record the last emitted make; a break matching {code, ext} SHALL clear it.
REQ-021 With REPEAT_FILTER=1, a make matching a valid held register SHALL be suppressed: no push, no last_make update.
REQ-022 Each non-suppressed make SHALL load last_make on the same edge, whether or not the FIFO has room.
REQ-023 The FIFO SHALL be first-word-fall-through: evt_code/evt_ext/evt_break reflect the head entry; evt_valid = (fifo_count != 0).
REQ-024 A pop SHALL occur on an edge where evt_valid=1 and evt_ready=1; evt_ready while empty is ignored.
REQ-025 Latency: an event created by the byte strobed in cycle N SHALL be visible with evt_valid=1 in cycle N+1 when the FIFO was empty.
REQ-026 Push while full without a simultaneous pop SHALL drop the event, leave contents unchanged, and set overflow.
REQ-027 Simultaneous push and pop SHALL both take effect with fifo_count unchanged, including when full.
REQ-028 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL saturate neither below 0 nor above FIFO_DEPTH.
REQ-029 Head outputs SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-030 overflow SHALL clear only on reset.

Reset
REQ-031 reset=0 SHALL immediately force: FSM IDLE, pointers 0, fifo_count 0, evt_valid 0, evt_code 00, evt_ext 0, evt_break 0, overflow 0, last_make 00, held.valid 0.
REQ-032 Assertion mid-sequence (after E0 or F0) SHALL discard the pending prefix; the next byte after release parses from IDLE.
REQ-033 Operation SHALL resume on the first rising edge after reset returns to 1.

Verification
REQ-034 Bytes 1C, F0, 1C, evt_ready=1 -> events {1C,0,0} then {1C,0,1}; last_make=1C; evt_valid one cycle after each final byte.
REQ-035 Bytes E0, 75, E0, F0, 75 -> events {75,1,0} then {75,1,1}.
REQ-036 REPEAT_FILTER=1, bytes 1C, 1C, 1C, F0, 1C, 1C -> events {1C,0,0}, {1C,0,1}, {1C,0,0}.
REQ-037 evt_ready=0, six distinct makes 15,1D,24,2D,2C,35 -> fifo_count=4, overflow=1, pops yield 15,1D,24,2D; last_make=35.
REQ-038 Full FIFO, byte_valid and pop in the same cycle -> fifo_count stays 4, overflow stays 0, new code appears at tail.
REQ-039 Bytes E0, AA, 1C -> event {1C,0,0}; bytes F0 then reset pulse then 1C -> event {1C,0,0}, all outputs zero during reset.
